// File: rtl/uart_test_ctrl.sv
// uart_test_ctrl: run-time test controller for the UART FIFO interface.
// Modes: 0 manual send, 1 arithmetic loopback, 2 burst generate + receive check, 3 receive sink.
// Ports:
//   clk, reset (async, active-low)
//   mode, send, clr, w_sw         : board controls (mode sampled only while idle)
//   tx_full, rx_empty, r_data     : UART FIFO status / RX head word
//   rd_uart, wr_uart, w_data      : FIFO pop/push strobes and push data (combinational)
//   rec_data, rx_cnt, err_cnt     : last popped word and saturating counters
//   busy, led                     : burst in progress, status display
module uart_test_ctrl #(
    parameter int unsigned DBIT      = 8,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             send,
    input  logic             clr,
    input  logic [DBIT-1:0]  w_sw,
    input  logic             tx_full,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  r_data,
    output logic             rd_uart,
    output logic             wr_uart,
    output logic [DBIT-1:0]  w_data,
    output logic [DBIT-1:0]  rec_data,
    output logic [CNT_W-1:0] rx_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             busy,
    output logic [7:0]       led
);

    localparam int unsigned BcntW = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e            state_q, state_d;
    logic [1:0]        act_mode_q, act_mode_d;
    logic              send_q;
    logic [DBIT-1:0]   seq_q, seq_d;
    logic [DBIT-1:0]   exp_q, exp_d;
    logic [BcntW-1:0]  bcnt_q, bcnt_d;
    logic [DBIT-1:0]   rec_data_q;
    logic [CNT_W-1:0]  rx_cnt_q, err_cnt_q;
    logic              drop_q, rx_tgl_q;

    logic send_tick;
    logic drop_set;
    logic err_inc;

    assign send_tick = send & ~send_q;

    always_comb begin
        state_d    = state_q;
        act_mode_d = act_mode_q;
        seq_d      = seq_q;
        exp_d      = exp_q;
        bcnt_d     = bcnt_q;
        rd_uart    = 1'b0;
        wr_uart    = 1'b0;
        w_data     = '0;
        drop_set   = 1'b0;
        err_inc    = 1'b0;

        if (state_q == StIdle) begin
            act_mode_d = mode;
        end

        unique case (act_mode_q)
            2'd0: begin
                rd_uart = ~rx_empty;
                if (send_tick) begin
                    if (!tx_full) begin
                        wr_uart = 1'b1;
                        w_data  = w_sw;
                    end else begin
                        drop_set = 1'b1;
                    end
                end
            end
            2'd1: begin
                // Pop and push together so a full TX FIFO leaves the word in RX.
                if (!rx_empty && !tx_full) begin
                    rd_uart = 1'b1;
                    wr_uart = 1'b1;
                    w_data  = r_data + w_sw;
                end
            end
            2'd2: begin
                rd_uart = ~rx_empty;
                if (!rx_empty) begin
                    err_inc = (r_data != exp_q);
                    exp_d   = r_data + DBIT'(1);
                end
                if (state_q == StBurst && !tx_full) begin
                    wr_uart = 1'b1;
                    w_data  = seq_q;
                    seq_d   = seq_q + DBIT'(1);
                    bcnt_d  = bcnt_q + BcntW'(1);
                    if (bcnt_q == BcntW'(BURST_LEN - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            2'd3: begin
                rd_uart = ~rx_empty;
            end
            default: ;
        endcase

        // Burst entry overrides any receive-side update of exp in the same cycle.
        if (state_q == StIdle && send_tick && mode == 2'd2) begin
            state_d = StBurst;
            seq_d   = w_sw;
            exp_d   = w_sw;
            bcnt_d  = '0;
        end

        // Strobes must be quiet while reset is held, not just after the first edge.
        if (!reset) begin
            rd_uart  = 1'b0;
            wr_uart  = 1'b0;
            w_data   = '0;
            drop_set = 1'b0;
            err_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            act_mode_q <= 2'd0;
            send_q     <= 1'b0;
            seq_q      <= '0;
            exp_q      <= '0;
            bcnt_q     <= '0;
            rec_data_q <= '0;
            rx_cnt_q   <= '0;
            err_cnt_q  <= '0;
            drop_q     <= 1'b0;
            rx_tgl_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_mode_q <= act_mode_d;
            send_q     <= send;
            seq_q      <= seq_d;
            exp_q      <= exp_d;
            bcnt_q     <= bcnt_d;
            if (rd_uart) begin
                rec_data_q <= r_data;
                rx_tgl_q   <= ~rx_tgl_q;
            end
            if (clr) begin
                rx_cnt_q  <= '0;
                err_cnt_q <= '0;
                drop_q    <= 1'b0;
            end else begin
                if (rd_uart && rx_cnt_q != CntMax) rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                if (err_inc && err_cnt_q != CntMax) err_cnt_q <= err_cnt_q + CNT_W'(1);
                if (drop_set) drop_q <= 1'b1;
            end
        end
    end

    assign rec_data = rec_data_q;
    assign rx_cnt   = rx_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign busy     = (state_q == StBurst);
    assign led      = {busy, ~tx_full, drop_q, |err_cnt_q, ~rx_empty, act_mode_q, rx_tgl_q};

endmodule

// File: tb/tb_uart_test_ctrl.sv
// Self-checking bench for uart_test_ctrl (DBIT=8, BURST_LEN=4, CNT_W=2).
module tb_uart_test_ctrl;

    localparam int unsigned BL   = 4;
    localparam int          CMAX = 3;

    logic       clk, reset, send, clr, tx_full, rx_empty;
    logic [1:0] mode;
    logic [7:0] w_sw, r_data, w_data, rec_data, led;
    logic       rd_uart, wr_uart, busy;
    logic [1:0] rx_cnt, err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int         m_rx = 0;
    int         m_err = 0;
    logic       m_drop = 1'b0;
    logic       m_tgl = 1'b0;
    logic [7:0] m_rec = 8'h00;
    logic [7:0] m_exp = 8'h00;

    uart_test_ctrl #(.DBIT(8), .BURST_LEN(BL), .CNT_W(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .send(send), .clr(clr), .w_sw(w_sw),
        .tx_full(tx_full), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .wr_uart(wr_uart), .w_data(w_data), .rec_data(rec_data), .rx_cnt(rx_cnt),
        .err_cnt(err_cnt), .busy(busy), .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic m_pop(input logic [7:0] d, input bit check);
        m_rec = d;
        m_tgl = ~m_tgl;
        if (m_rx < CMAX) m_rx++;
        if (check) begin
            if (d != m_exp && m_err < CMAX) m_err++;
            m_exp = d + 8'd1;
        end
    endtask

    task automatic m_clr();
        m_rx = 0;
        m_err = 0;
        m_drop = 1'b0;
    endtask

    function automatic logic [7:0] led_exp(input logic b, input logic [1:0] am);
        return {b, ~tx_full, m_drop, (m_err != 0), ~rx_empty, am, m_tgl};
    endfunction

    // Starts a burst from the drive window and runs it to completion.
    task automatic run_burst(input logic [7:0] seed, input int s_lo, input int s_hi,
                             input bit rnd, output int nb, output int ns);
        logic [7:0] q[$];
        logic [7:0] ed;
        bit done;
        nb = 0;
        ns = 0;
        done = 1'b0;
        w_sw = seed;
        send = 1'b1;
        @(negedge clk);
        chk("bst_idle_before", busy, 1'b0);
        m_exp = seed;
        cyc();
        send = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            tx_full = rnd ? 1'($urandom_range(0, 1)) : (c >= s_lo && c <= s_hi);
            if (c == 2) mode = 2'd1;  // must not affect a running burst
            @(negedge clk);
            if (busy) begin
                nb++;
                if (tx_full) ns++;
                chk("bst_wr", wr_uart, !tx_full);
                chk("bst_actmode", led[2:1], 2'd2);
                if (wr_uart) begin
                    ed = seed + 8'(q.size());
                    chk("bst_data", w_data, ed);
                    q.push_back(w_data);
                end
            end else begin
                done = 1'b1;
                chk("bst_no_push_after", wr_uart, 1'b0);
            end
            cyc();
        end
        chk("bst_done", done, 1'b1);
        chk("bst_pushes", q.size(), BL);
        tx_full = 1'b0;
        mode = 2'd2;
        cyc();
        cyc();
    endtask

    initial begin
        int nw, nb, ns;
        logic [7:0] ev;
        logic p;
        logic [7:0] feed[4];
        feed[0] = 8'hFE; feed[1] = 8'hFF; feed[2] = 8'h05; feed[3] = 8'h06;

        // Reset: strobes quiet even with RX data and send held.
        reset = 1'b0; mode = 2'd0; send = 1'b1; clr = 1'b0; w_sw = 8'h00;
        tx_full = 1'b0; rx_empty = 1'b0; r_data = 8'h33;
        @(negedge clk);
        chk("rst_rd", rd_uart, 1'b0);
        chk("rst_wr", wr_uart, 1'b0);
        chk("rst_wdata", w_data, 8'h00);
        rx_empty = 1'b1;
        send = 1'b0;
        cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_led", led, 8'h40);
        chk("rst_rxcnt", rx_cnt, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_rec", rec_data, 0);
        chk("rst_busy", busy, 0);

        // MANUAL: one push per press.
        cyc();
        w_sw = 8'h5A;
        send = 1'b1;
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_uart) begin
                nw++;
                chk("man_wdata", w_data, 8'h5A);
            end
            cyc();
        end
        chk("man_pushes", nw, 1);
        send = 1'b0;
        cyc();
        tx_full = 1'b1;
        send = 1'b1;
        nw = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wr_uart) nw++;
            cyc();
        end
        chk("man_full_pushes", nw, 0);
        m_drop = 1'b1;
        @(negedge clk);
        chk("man_drop_led", led, led_exp(1'b0, 2'd0));
        cyc();
        send = 1'b0;
        tx_full = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        m_clr();
        cyc();
        clr = 1'b0;
        @(negedge clk);
        chk("man_clr_drop", led[5], 1'b0);

        // LOOPBACK directed.
        cyc();
        mode = 2'd1;
        cyc();
        cyc();
        w_sw = 8'h01;
        r_data = 8'hFF;
        rx_empty = 1'b0;
        @(negedge clk);
        chk("lb_rd", rd_uart, 1'b1);
        chk("lb_wr", wr_uart, 1'b1);
        chk("lb_wdata", w_data, 8'h00);
        m_pop(8'hFF, 1'b0);
        cyc();
        rx_empty = 1'b1;
        @(negedge clk);
        chk("lb_rec", rec_data, 8'hFF);
        chk("lb_rxcnt", rx_cnt, 1);
        cyc();
        tx_full = 1'b1;
        rx_empty = 1'b0;
        @(negedge clk);
        chk("lb_full_rd", rd_uart, 1'b0);
        chk("lb_full_wr", wr_uart, 1'b0);

        // LOOPBACK randomized.
        for (int i = 0; i < 24; i++) begin
            cyc();
            r_data = 8'($urandom);
            w_sw = 8'($urandom);
            rx_empty = 1'($urandom_range(0, 1));
            tx_full = 1'($urandom_range(0, 1));
            send = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("lbr_rxcnt", rx_cnt, m_rx);
            chk("lbr_rec", rec_data, m_rec);
            p = !rx_empty && !tx_full;
            chk("lbr_rd", rd_uart, p);
            chk("lbr_wr", wr_uart, p);
            if (p) begin
                ev = r_data + w_sw;
                chk("lbr_wdata", w_data, ev);
                m_pop(r_data, 1'b0);
            end
        end
        cyc();
        rx_empty = 1'b1;
        tx_full = 1'b0;
        send = 1'b0;
        @(negedge clk);
        chk("lbr_rxcnt_end", rx_cnt, m_rx);
        chk("lbr_led", led, led_exp(1'b0, 2'd1));

        // BURST directed with a 3-cycle stall and a mode change mid-burst.
        cyc();
        mode = 2'd2;
        clr = 1'b1;
        @(negedge clk);
        m_clr();
        cyc();
        clr = 1'b0;
        cyc();
        run_burst(8'hFE, 1, 3, 1'b0, nb, ns);
        chk("bst_busy_len", nb, BL + 3);

        // BURST receive check.
        for (int i = 0; i < 4; i++) begin
            rx_empty = 1'b0;
            r_data = feed[i];
            @(negedge clk);
            chk("chk_rd", rd_uart, 1'b1);
            m_pop(feed[i], 1'b1);
            cyc();
        end
        rx_empty = 1'b1;
        @(negedge clk);
        chk("chk_errcnt", err_cnt, m_err);
        chk("chk_errcnt_one", err_cnt, 1);
        chk("chk_rxcnt", rx_cnt, m_rx);
        chk("chk_led4", led[4], 1'b1);

        // BURST randomized: random seed and stalls, then random receive stream.
        cyc();
        run_burst(8'($urandom), 0, -1, 1'b1, nb, ns);
        chk("bstr_busy_len", nb, BL + ns);
        clr = 1'b1;
        @(negedge clk);
        m_clr();
        cyc();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rx_empty = 1'($urandom_range(0, 1));
            r_data = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_exp;
            @(negedge clk);
            chk("chkr_errcnt", err_cnt, m_err);
            chk("chkr_rd", rd_uart, !rx_empty);
            if (!rx_empty) m_pop(r_data, 1'b1);
            cyc();
        end
        rx_empty = 1'b1;

        // SINK: saturation, no pushes, clr wins over a coincident pop.
        mode = 2'd3;
        clr = 1'b1;
        @(negedge clk);
        m_clr();
        cyc();
        clr = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            rx_empty = 1'b0;
            r_data = 8'($urandom);
            send = 1'(i % 2);
            @(negedge clk);
            chk("snk_rd", rd_uart, 1'b1);
            chk("snk_wr", wr_uart, 1'b0);
            m_pop(r_data, 1'b0);
            cyc();
        end
        rx_empty = 1'b1;
        send = 1'b0;
        @(negedge clk);
        chk("snk_sat", rx_cnt, 3);
        cyc();
        clr = 1'b1;
        rx_empty = 1'b0;
        r_data = 8'h3C;
        @(negedge clk);
        chk("snk_clr_rd", rd_uart, 1'b1);
        m_pop(8'h3C, 1'b0);
        m_clr();
        cyc();
        clr = 1'b0;
        rx_empty = 1'b1;
        @(negedge clk);
        chk("snk_clr_cnt", rx_cnt, 0);
        chk("snk_rec", rec_data, 8'h3C);
        chk("snk_led", led, led_exp(1'b0, 2'd3));

        // Reset mid-burst.
        cyc();
        mode = 2'd2;
        cyc();
        cyc();
        w_sw = 8'h10;
        send = 1'b1;
        @(negedge clk);
        cyc();
        send = 1'b0;
        @(negedge clk);
        chk("rmb_first_push", wr_uart, 1'b1);
        chk("rmb_first_data", w_data, 8'h10);
        cyc();
        @(negedge clk);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        m_clr();
        m_tgl = 1'b0;
        chk("rmb_wr", wr_uart, 1'b0);
        chk("rmb_busy", busy, 1'b0);
        chk("rmb_led", led, 8'h40);
        chk("rmb_rec", rec_data, 8'h00);
        cyc();
        reset = 1'b1;
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_uart) nw++;
            cyc();
        end
        chk("rmb_no_push", nw, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
